dtcm_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the single-port dtcm RAM (8K x 32, byte enables, 1-cycle read).

---
 rtl/dtcm_pkg.sv | 25 ++
 rtl/dtcm.sv | 51 +++++
 rtl/dtcm_rsp_fifo.sv | 64 ++++++
 rtl/dtcm_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dtcm_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtcm_pkg.sv
// ============================================================================
// Module   : dtcm_pkg
// Brief    : Shared widths, arbitration modes and in-flight tag for dtcm access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dtcm_pkg;

    localparam int DTCM_ADDR_W = 13;
    localparam int DTCM_DATA_W = 32;
    localparam int DTCM_BE_W   = 4;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Read issued last cycle: which port owns the dtcm rd_data arriving now.
    typedef struct packed {
        logic valid;
        logic port;
    } dtcm_tag_t;

endpackage

`default_nettype wire

// File: rtl/dtcm.sv
// ============================================================================
// Module   : dtcm
// Brief    : Single-port tightly coupled RAM, byte-write enables, 1-cycle read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtcm
    import dtcm_pkg::*;
#(
    parameter int ADDR_W = DTCM_ADDR_W,
    parameter int DATA_W = DTCM_DATA_W,
    parameter int BE_W   = DTCM_BE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [BE_W-1:0]   i_wr_byte_en,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_wr_byte_en[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (!i_wr_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/dtcm_rsp_fifo.sv
// ============================================================================
// Module   : dtcm_rsp_fifo
// Brief    : 2-entry first-word-fall-through read response FIFO with count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtcm_rsp_fifo
    import dtcm_pkg::*;
#(
    parameter int DATA_W = DTCM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_cnt;
    logic              w_pop;

    assign w_pop   = i_pop && (r_cnt != 2'd0);
    assign o_valid = (r_cnt != 2'd0);
    assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_cnt;

    // Push into a full FIFO is only legal with a pop: the slot written is the head being read out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && (r_cnt == 2'd2) && !w_pop));
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/dtcm_arbiter.sv
// ============================================================================
// Module   : dtcm_arbiter
// Brief    : Two-port arbiter in front of the dtcm with per-port read FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtcm_arbiter
    import dtcm_pkg::*;
#(
    parameter int ADDR_WIDTH   = DTCM_ADDR_W,
    parameter int DATA_WIDTH   = DTCM_DATA_W,
    parameter int BE_WIDTH     = DTCM_BE_W,
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    input  logic [BE_WIDTH-1:0]   p0_req_be,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    input  logic [BE_WIDTH-1:0]   p1_req_be,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata
);

    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);

    logic                  w_rst;
    logic [1:0]            w_req_valid;
    logic [1:0]            w_req_we;
    logic [1:0]            w_rsp_ready;
    logic [1:0]            w_rsp_valid;
    logic [1:0]            w_pop;
    logic [1:0]            w_inflight;
    logic [1:0]            w_credit_ok;
    logic [1:0]            w_elig;
    logic [ADDR_WIDTH-1:0] w_req_addr  [2];
    logic [DATA_WIDTH-1:0] w_req_wdata [2];
    logic [BE_WIDTH-1:0]   w_req_be    [2];
    logic [DATA_WIDTH-1:0] w_rsp_rdata [2];
    logic [1:0]            w_fifo_cnt  [2];

    logic                  w_gnt_any;
    logic                  w_gnt_port;
    logic [ADDR_WIDTH-1:0] w_dtcm_addr;
    logic                  w_dtcm_wr_en;
    logic [DATA_WIDTH-1:0] w_dtcm_wdata;
    logic [BE_WIDTH-1:0]   w_dtcm_be;
    logic [DATA_WIDTH-1:0] w_dtcm_rdata;

    logic                  r_rr_ptr;
    logic [7:0]            r_starve_cnt;
    dtcm_tag_t             r_tag;
    logic [ADDR_WIDTH-1:0] r_addr_hold;

    assign w_rst          = ~rst_n;
    assign w_req_valid    = {p1_req_valid, p0_req_valid};
    assign w_req_we       = {p1_req_we, p0_req_we};
    assign w_rsp_ready    = {p1_rsp_ready, p0_rsp_ready};
    assign w_req_addr[0]  = p0_req_addr;
    assign w_req_addr[1]  = p1_req_addr;
    assign w_req_wdata[0] = p0_req_wdata;
    assign w_req_wdata[1] = p1_req_wdata;
    assign w_req_be[0]    = p0_req_be;
    assign w_req_be[1]    = p1_req_be;

    // A read is only eligible when its response is guaranteed a FIFO slot.
    for (genvar n = 0; n < 2; n++) begin : g_port
        assign w_inflight[n]  = r_tag.valid && (r_tag.port == 1'(n));
        assign w_pop[n]       = w_rsp_valid[n] & w_rsp_ready[n];
        assign w_credit_ok[n] = ({1'b0, w_fifo_cnt[n]} + {2'b00, w_inflight[n]}
                                 - {2'b00, w_pop[n]}) < 3'd2;
        assign w_elig[n]      = rst_n & w_req_valid[n] & (w_req_we[n] | w_credit_ok[n]);

        dtcm_rsp_fifo #(
            .DATA_W (DATA_WIDTH)
        ) u_rsp_fifo (
            .clk     (clk),
            .rst     (w_rst),
            .i_push  (w_inflight[n]),
            .i_wdata (w_dtcm_rdata),
            .i_pop   (w_rsp_ready[n]),
            .o_valid (w_rsp_valid[n]),
            .o_rdata (w_rsp_rdata[n]),
            .o_count (w_fifo_cnt[n])
        );
    end

    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_port = 1'b0;
        if (w_elig == 2'b11) begin
            w_gnt_any = 1'b1;
            if (PRIO_MODE == PRIO_FIXED) begin
                w_gnt_port = (r_starve_cnt == c_starve_limit);
            end else begin
                w_gnt_port = r_rr_ptr;
            end
        end else if (w_elig[0]) begin
            w_gnt_any = 1'b1;
        end else if (w_elig[1]) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = 1'b1;
        end
    end

    assign p0_req_ready = w_gnt_any & ~w_gnt_port;
    assign p1_req_ready = w_gnt_any & w_gnt_port;

    // With no grant the address is parked on its last value to avoid needless toggling.
    assign w_dtcm_addr  = w_gnt_any ? w_req_addr[w_gnt_port] : r_addr_hold;
    assign w_dtcm_wr_en = w_gnt_any & w_req_we[w_gnt_port];
    assign w_dtcm_wdata = w_req_wdata[w_gnt_port];
    assign w_dtcm_be    = w_req_be[w_gnt_port];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr     <= 1'b0;
            r_starve_cnt <= 8'd0;
            r_tag        <= '0;
            r_addr_hold  <= '0;
        end else begin
            r_tag.valid <= w_gnt_any & ~w_dtcm_wr_en;
            r_tag.port  <= w_gnt_port;
            r_addr_hold <= w_dtcm_addr;
            if (w_gnt_any) begin
                r_rr_ptr <= ~w_gnt_port;
            end
            if (w_gnt_any && w_gnt_port) begin
                r_starve_cnt <= 8'd0;
            end else if (w_elig[1] && (r_starve_cnt != c_starve_limit)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    dtcm #(
        .ADDR_W (ADDR_WIDTH),
        .DATA_W (DATA_WIDTH),
        .BE_W   (BE_WIDTH)
    ) u_dtcm (
        .clk          (clk),
        .rst          (w_rst),
        .i_addr       (w_dtcm_addr),
        .i_wr_en      (w_dtcm_wr_en),
        .i_wr_data    (w_dtcm_wdata),
        .i_wr_byte_en (w_dtcm_be),
        .o_rd_data    (w_dtcm_rdata)
    );

    assign p0_rsp_valid = w_rsp_valid[0];
    assign p1_rsp_valid = w_rsp_valid[1];
    assign p0_rsp_rdata = w_rsp_rdata[0];
    assign p1_rsp_rdata = w_rsp_rdata[1];

endmodule

`default_nettype wire

// File: tb/tb_dtcm_arbiter.sv
// ============================================================================
// Module   : tb_dtcm_arbiter
// Brief    : Self-checking bench: round-robin instance with reference model,
//            fixed-priority instance for starvation and reset-in-flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dtcm_arbiter;

    logic clk;
    logic a_rst_n, b_rst_n;

    logic        a_valid [2], a_we [2], a_ready [2], a_rsp_valid [2], a_rsp_ready [2];
    logic [12:0] a_addr [2];
    logic [31:0] a_wdata [2], a_rdata [2];
    logic [3:0]  a_be [2];

    logic        b_valid [2], b_we [2], b_ready [2], b_rsp_valid [2], b_rsp_ready [2];
    logic [12:0] b_addr [2];
    logic [31:0] b_wdata [2], b_rdata [2];
    logic [3:0]  b_be [2];

    int checks   = 0;
    int failures = 0;

    dtcm_arbiter #(.PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst_n(a_rst_n),
        .p0_req_valid(a_valid[0]), .p0_req_ready(a_ready[0]), .p0_req_we(a_we[0]),
        .p0_req_addr(a_addr[0]), .p0_req_wdata(a_wdata[0]), .p0_req_be(a_be[0]),
        .p0_rsp_valid(a_rsp_valid[0]), .p0_rsp_ready(a_rsp_ready[0]), .p0_rsp_rdata(a_rdata[0]),
        .p1_req_valid(a_valid[1]), .p1_req_ready(a_ready[1]), .p1_req_we(a_we[1]),
        .p1_req_addr(a_addr[1]), .p1_req_wdata(a_wdata[1]), .p1_req_be(a_be[1]),
        .p1_rsp_valid(a_rsp_valid[1]), .p1_rsp_ready(a_rsp_ready[1]), .p1_rsp_rdata(a_rdata[1])
    );

    dtcm_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(8)) dut_pr (
        .clk(clk), .rst_n(b_rst_n),
        .p0_req_valid(b_valid[0]), .p0_req_ready(b_ready[0]), .p0_req_we(b_we[0]),
        .p0_req_addr(b_addr[0]), .p0_req_wdata(b_wdata[0]), .p0_req_be(b_be[0]),
        .p0_rsp_valid(b_rsp_valid[0]), .p0_rsp_ready(b_rsp_ready[0]), .p0_rsp_rdata(b_rdata[0]),
        .p1_req_valid(b_valid[1]), .p1_req_ready(b_ready[1]), .p1_req_we(b_we[1]),
        .p1_req_addr(b_addr[1]), .p1_req_wdata(b_wdata[1]), .p1_req_be(b_be[1]),
        .p1_rsp_valid(b_rsp_valid[1]), .p1_rsp_ready(b_rsp_ready[1]), .p1_rsp_rdata(b_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model for the round-robin instance: outstanding reads per port
    // (granted, not yet consumed), each carrying its grant cycle and data.
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t        m_q0 [$];
    rsp_t        m_q1 [$];
    logic [31:0] m_mem [int];
    logic        m_pref  = 1'b0;
    int          m_cycle = 0;

    function automatic int q_size(int n);
        return (n == 0) ? m_q0.size() : m_q1.size();
    endfunction

    function automatic logic exp_vld(int n);
        if (q_size(n) == 0) return 1'b0;
        return ((n == 0) ? m_q0[0].cyc : m_q1[0].cyc) + 2 <= m_cycle;
    endfunction

    function automatic logic [31:0] exp_data(int n);
        return (n == 0) ? m_q0[0].data : m_q1[0].data;
    endfunction

    function automatic logic [1:0] exp_grant();
        logic [1:0] el;
        int         pending;
        for (int n = 0; n < 2; n++) begin
            pending = q_size(n) - ((exp_vld(n) && a_rsp_ready[n]) ? 1 : 0);
            el[n] = a_rst_n && a_valid[n] && (a_we[n] || pending < 2);
        end
        if (el == 2'b11) return m_pref ? 2'b10 : 2'b01;
        return el;
    endfunction

    task automatic model_step();
        logic [1:0]  g;
        logic [1:0]  pp;
        logic [31:0] w;
        int          p;
        int          ad;
        g     = exp_grant();
        pp[0] = exp_vld(0) && a_rsp_ready[0];
        pp[1] = exp_vld(1) && a_rsp_ready[1];
        if (!a_rst_n) begin
            m_q0.delete();
            m_q1.delete();
            m_pref = 1'b0;
        end else begin
            if (pp[0]) void'(m_q0.pop_front());
            if (pp[1]) void'(m_q1.pop_front());
            if (g != 2'b00) begin
                p  = g[1] ? 1 : 0;
                ad = int'(a_addr[p]);
                w  = m_mem.exists(ad) ? m_mem[ad] : 32'h0;
                if (a_we[p]) begin
                    for (int b = 0; b < 4; b++)
                        if (a_be[p][b]) w[8*b +: 8] = a_wdata[p][8*b +: 8];
                    m_mem[ad] = w;
                end else if (p == 0) begin
                    m_q0.push_back('{cyc: m_cycle, data: w});
                end else begin
                    m_q1.push_back('{cyc: m_cycle, data: w});
                end
                m_pref = (p == 0);
            end
        end
        m_cycle++;
    endtask

    // Every clock advance goes through here so the model sees each edge.
    task automatic next();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic a_idle();
        for (int n = 0; n < 2; n++) begin
            a_valid[n] = 1'b0; a_we[n] = 1'b0; a_addr[n] = '0; a_wdata[n] = '0; a_be[n] = '0;
        end
    endtask

    task automatic a_write(int n, logic [12:0] ad, logic [31:0] d);
        a_idle();
        a_valid[n] = 1'b1; a_we[n] = 1'b1; a_addr[n] = ad; a_wdata[n] = d; a_be[n] = 4'hF;
        next();
        a_idle();
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            a_valid[n] = 1'b1; a_we[n] = 1'b1; a_addr[n] = '0; a_wdata[n] = '0; a_be[n] = 4'hF;
            a_rsp_ready[n] = 1'b1;
            b_valid[n] = 1'b0; b_we[n] = 1'b0; b_addr[n] = '0; b_wdata[n] = '0; b_be[n] = '0;
            b_rsp_ready[n] = 1'b1;
        end
        next();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                checks++;
                if (a_ready[n] !== 1'b0) begin
                    failures++; $display("FAIL reset_req_ready p%0d: got %b want 0", n, a_ready[n]);
                end
                checks++;
                if (a_rsp_valid[n] !== 1'b0 || a_rdata[n] !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_rsp p%0d: got valid=%b rdata=%h want 0/0", n, a_rsp_valid[n], a_rdata[n]);
                end
            end
            next();
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready[0] !== 1'b1 || a_ready[1] !== 1'b0) begin
            failures++; $display("FAIL reset_first_grant: got %b%b want p0", a_ready[1], a_ready[0]);
        end
        next();
        @(negedge clk);
        checks++;
        if (a_ready[0] !== 1'b0 || a_ready[1] !== 1'b1) begin
            failures++; $display("FAIL reset_second_grant: got %b%b want p1", a_ready[1], a_ready[0]);
        end
        next();
        a_idle();
        next();
    endtask

    task automatic test_single_port();
        a_valid[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 13'h1FFF; a_wdata[0] = 32'hDEADBEEF; a_be[0] = 4'hF;
        @(negedge clk);
        checks++;
        if (a_ready[0] !== 1'b1) begin failures++; $display("FAIL sp_write_grant: got %b want 1", a_ready[0]); end
        next();
        a_we[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready[0] !== 1'b1) begin failures++; $display("FAIL sp_read_grant: got %b want 1", a_ready[0]); end
        next();
        a_idle();
        @(negedge clk);
        checks++;
        if (a_rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL sp_rsp_early: got %b want 0", a_rsp_valid[0]); end
        next();
        @(negedge clk);
        checks++;
        if (a_rsp_valid[0] !== 1'b1 || a_rdata[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sp_rsp_data: got valid=%b rdata=%h want 1/deadbeef", a_rsp_valid[0], a_rdata[0]);
        end
        next();
        @(negedge clk);
        checks++;
        if (a_rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL sp_rsp_drained: got %b want 0", a_rsp_valid[0]); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] wd [3] = '{32'h11223344, 32'hAABBCCDD, 32'hFFFFFFFF};
        logic [3:0]  be [3] = '{4'hF, 4'b0101, 4'h0};
        for (int i = 0; i < 4; i++) begin
            a_valid[0] = 1'b1; a_addr[0] = 13'd5;
            a_we[0]    = (i < 3);
            a_wdata[0] = (i < 3) ? wd[i] : 32'h0;
            a_be[0]    = (i < 3) ? be[i] : 4'h0;
            @(negedge clk);
            checks++;
            if (a_ready[0] !== 1'b1) begin failures++; $display("FAIL be_grant step%0d: got %b want 1", i, a_ready[0]); end
            next();
        end
        a_idle();
        next();
        @(negedge clk);
        checks++;
        if (a_rsp_valid[0] !== 1'b1 || a_rdata[0] !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL be_merge: got valid=%b rdata=%h want 1/11bb33dd", a_rsp_valid[0], a_rdata[0]);
        end
        next();
    endtask

    logic [31:0] exp0 [8];
    logic [31:0] exp1 [8];

    task automatic test_rr_contention();
        int i0 = 0, i1 = 0, r0 = 0, r1 = 0, ngr = 0, ngr16 = 0, last = -1, cur;
        for (int i = 0; i < 8; i++) begin
            exp0[i] = $urandom; a_write(0, 13'h100 + 13'(i), exp0[i]);
            exp1[i] = $urandom; a_write(0, 13'h180 + 13'(i), exp1[i]);
        end
        a_rsp_ready[0] = 1'b1; a_rsp_ready[1] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            a_valid[0] = (i0 < 8); a_we[0] = 1'b0; a_addr[0] = 13'h100 + 13'(i0);
            a_valid[1] = (i1 < 8); a_we[1] = 1'b0; a_addr[1] = 13'h180 + 13'(i1);
            @(negedge clk);
            if (c < 16) begin
                checks++;
                if (!((a_ready[0] === 1'b1) ^ (a_ready[1] === 1'b1))) begin
                    failures++; $display("FAIL rr_onehot cyc%0d: got %b%b want one grant", c, a_ready[1], a_ready[0]);
                end
                cur = (a_ready[1] === 1'b1) ? 1 : 0;
                if (last >= 0) begin
                    checks++;
                    if (cur == last) begin failures++; $display("FAIL rr_alternate cyc%0d: got p%0d twice want alternate", c, cur); end
                end
                last = cur;
            end
            if (a_rsp_valid[0] === 1'b1) begin
                checks++;
                if (r0 >= 8 || a_rdata[0] !== exp0[r0 % 8]) begin
                    failures++; $display("FAIL rr_rsp_p0 #%0d: got %h want %h", r0, a_rdata[0], exp0[r0 % 8]);
                end
                r0++;
            end
            if (a_rsp_valid[1] === 1'b1) begin
                checks++;
                if (r1 >= 8 || a_rdata[1] !== exp1[r1 % 8]) begin
                    failures++; $display("FAIL rr_rsp_p1 #%0d: got %h want %h", r1, a_rdata[1], exp1[r1 % 8]);
                end
                r1++;
            end
            if (a_ready[0] === 1'b1) begin i0++; ngr++; end
            if (a_ready[1] === 1'b1) begin i1++; ngr++; end
            if (c == 15) ngr16 = ngr;
            next();
        end
        a_idle();
        checks++;
        if (ngr16 != 16) begin failures++; $display("FAIL rr_grant_count: got %0d want 16 in 16 cycles", ngr16); end
        checks++;
        if (r0 != 8 || r1 != 8) begin failures++; $display("FAIL rr_rsp_count: got %0d/%0d want 8/8", r0, r1); end
    endtask

    task automatic test_back_pressure();
        int i1 = 0, r1 = 0;
        a_rsp_ready[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            a_valid[1] = (i1 < 4); a_we[1] = 1'b0; a_addr[1] = 13'h180 + 13'(i1);
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (a_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_held cyc%0d: got %b want 0", c, a_ready[1]); end
            end
            if (a_ready[1] === 1'b1) i1++;
            next();
        end
        checks++;
        if (i1 != 2) begin failures++; $display("FAIL bp_grants_blocked: got %0d want 2", i1); end
        a_rsp_ready[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a_valid[1] = (i1 < 4); a_addr[1] = 13'h180 + 13'(i1);
            @(negedge clk);
            if (a_rsp_valid[1] === 1'b1) begin
                checks++;
                if (r1 >= 4 || a_rdata[1] !== exp1[r1 % 8]) begin
                    failures++; $display("FAIL bp_rsp #%0d: got %h want %h", r1, a_rdata[1], exp1[r1 % 8]);
                end
                r1++;
            end
            if (a_ready[1] === 1'b1) i1++;
            next();
        end
        a_idle();
        checks++;
        if (i1 != 4 || r1 != 4) begin failures++; $display("FAIL bp_totals: got grants=%0d rsps=%0d want 4/4", i1, r1); end
    endtask

    task automatic test_random();
        logic [1:0] g;
        for (int i = 0; i < 16; i++) a_write(i % 2, 13'(i), $urandom);
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                a_valid[n]     = 1'($urandom_range(0, 1));
                a_we[n]        = ($urandom_range(0, 3) == 0);
                a_addr[n]      = 13'($urandom_range(0, 15));
                a_wdata[n]     = $urandom;
                a_be[n]        = 4'($urandom_range(0, 15));
                a_rsp_ready[n] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            g = exp_grant();
            for (int n = 0; n < 2; n++) begin
                checks++;
                if (a_ready[n] !== g[n]) begin
                    failures++; $display("FAIL rand_grant p%0d cyc%0d: got %b want %b", n, c, a_ready[n], g[n]);
                end
                checks++;
                if (a_rsp_valid[n] !== exp_vld(n)) begin
                    failures++; $display("FAIL rand_rsp_valid p%0d cyc%0d: got %b want %b", n, c, a_rsp_valid[n], exp_vld(n));
                end else if (exp_vld(n)) begin
                    checks++;
                    if (a_rdata[n] !== exp_data(n)) begin
                        failures++; $display("FAIL rand_rdata p%0d cyc%0d: got %h want %h", n, c, a_rdata[n], exp_data(n));
                    end
                end
            end
            next();
        end
        a_idle();
        a_rsp_ready[0] = 1'b1; a_rsp_ready[1] = 1'b1;
        repeat (4) next();
    endtask

    task automatic test_starvation();
        logic want1;
        for (int n = 0; n < 2; n++) begin
            b_valid[n] = 1'b1; b_we[n] = 1'b1; b_addr[n] = 13'h10; b_wdata[n] = '0; b_be[n] = 4'h0;
        end
        for (int i = 0; i < 36; i++) begin
            want1 = (i % 9 == 8);
            @(negedge clk);
            checks++;
            if (b_ready[1] !== want1 || b_ready[0] !== !want1) begin
                failures++;
                $display("FAIL starve_grant cyc%0d: got p1=%b p0=%b want p1=%b", i, b_ready[1], b_ready[0], want1);
            end
            next();
        end
        b_valid[0] = 1'b0; b_valid[1] = 1'b0;
        next();
    endtask

    task automatic test_reset_inflight();
        b_valid[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 13'h20;
        @(negedge clk);
        checks++;
        if (b_ready[1] !== 1'b1) begin failures++; $display("FAIL rst_inflight_grant: got %b want 1", b_ready[1]); end
        next();
        b_valid[1] = 1'b0; b_rst_n = 1'b0;
        next();
        next();
        b_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (b_rsp_valid[0] !== 1'b0 || b_rsp_valid[1] !== 1'b0) begin
                failures++;
                $display("FAIL rst_inflight_rsp cyc%0d: got %b%b want 00", i, b_rsp_valid[1], b_rsp_valid[0]);
            end
            next();
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_byte_enable();
        test_rr_contention();
        test_back_pressure();
        test_random();
        test_starvation();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
